// File: rtl/block_dispatch_ctrl.sv
// Dispatch controller: accepts one block at a time, launches it onto a run of
// consecutive cores via per-core valid/ready, then pulses a response once every launched core is done.
module block_dispatch_ctrl #(
  parameter int NUM_CORES = 4,
  parameter int NB_WIDTH  = 8,
  parameter int NC_WIDTH  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_valid,
  input  logic [NB_WIDTH-1:0]  req_id,
  input  logic [NC_WIDTH-1:0]  req_size_m1,
  input  logic [NC_WIDTH-1:0]  req_core_id,
  output logic                 req_ready,
  output logic [NUM_CORES-1:0] launch_valid,
  output logic [NB_WIDTH-1:0]  launch_id,
  input  logic [NUM_CORES-1:0] launch_ready,
  input  logic [NUM_CORES-1:0] done_valid,
  output logic                 rsp_valid,
  output logic [NB_WIDTH-1:0]  rsp_id,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam logic [NC_WIDTH-1:0] LAST_CORE = NC_WIDTH'(NUM_CORES - 1);

  state_e               state_q;
  logic                 ready_q;
  logic [NB_WIDTH-1:0]  id_q;
  logic [NC_WIDTH-1:0]  size_q;
  logic [NC_WIDTH-1:0]  cnt_q;
  logic [NC_WIDTH-1:0]  cur_q;
  logic [NUM_CORES-1:0] pending_q;

  logic [NUM_CORES-1:0] cur_onehot;
  logic [NUM_CORES-1:0] pending_kept;
  logic [NC_WIDTH-1:0]  req_core_mod;
  logic [NC_WIDTH-1:0]  req_size_clip;
  logic [NC_WIDTH-1:0]  next_core;
  logic                 handshake;

  assign cur_onehot    = NUM_CORES'(1) << cur_q;
  assign pending_kept  = pending_q & ~done_valid;
  assign req_core_mod  = NC_WIDTH'(32'(req_core_id) % NUM_CORES);
  assign req_size_clip = (req_size_m1 > LAST_CORE) ? LAST_CORE : req_size_m1;
  assign next_core     = (cur_q == LAST_CORE) ? '0 : cur_q + 1'b1;
  assign handshake     = |(launch_ready & cur_onehot);

  // Outputs decode only state and registers, so no input reaches them combinationally.
  assign req_ready    = ready_q;
  assign busy         = (state_q != IDLE);
  assign launch_valid = (state_q == LAUNCH) ? cur_onehot : '0;
  assign launch_id    = (state_q == LAUNCH) ? id_q : '0;
  assign rsp_valid    = (state_q == RESP);
  assign rsp_id       = (state_q == RESP) ? id_q : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ready_q   <= 1'b0;
      id_q      <= '0;
      size_q    <= '0;
      cnt_q     <= '0;
      cur_q     <= '0;
      pending_q <= '0;
    end else begin
      // NOTE: this default is overridden below by later non-blocking writes in the
      // same cycle; the last assignment wins, which is how launch-set beats done-clear.
      pending_q <= pending_kept;
      case (state_q)
        IDLE: begin
          if (req_valid && ready_q) begin
            id_q      <= req_id;
            size_q    <= req_size_clip;
            cur_q     <= req_core_mod;
            cnt_q     <= '0;
            pending_q <= '0;
            ready_q   <= 1'b0;
            state_q   <= LAUNCH;
          end else begin
            ready_q <= 1'b1;
          end
        end
        LAUNCH: begin
          if (handshake) begin
            pending_q <= pending_kept | cur_onehot;
            if (cnt_q == size_q) begin
              state_q <= WAIT;
            end else begin
              cnt_q <= cnt_q + 1'b1;
              cur_q <= next_core;
            end
          end
        end
        WAIT: begin
          if (pending_kept == '0) state_q <= RESP;
        end
        RESP: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_block_dispatch_ctrl.sv
// Directed bench for block_dispatch_ctrl: a vector table for the basic and
// wrap-around flows, plus hand-written back-pressure, done-collision, stall and reset sequences.
module tb_block_dispatch_ctrl;

  localparam int NUM_CORES = 4;
  localparam int NB_WIDTH  = 8;
  localparam int NC_WIDTH  = 2;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 req_valid;
  logic [NB_WIDTH-1:0]  req_id;
  logic [NC_WIDTH-1:0]  req_size_m1;
  logic [NC_WIDTH-1:0]  req_core_id;
  logic                 req_ready;
  logic [NUM_CORES-1:0] launch_valid;
  logic [NB_WIDTH-1:0]  launch_id;
  logic [NUM_CORES-1:0] launch_ready;
  logic [NUM_CORES-1:0] done_valid;
  logic                 rsp_valid;
  logic [NB_WIDTH-1:0]  rsp_id;
  logic                 busy;

  int n_checks = 0;
  int n_fail   = 0;

  block_dispatch_ctrl #(
    .NUM_CORES(NUM_CORES),
    .NB_WIDTH (NB_WIDTH),
    .NC_WIDTH (NC_WIDTH)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_id      (req_id),
    .req_size_m1 (req_size_m1),
    .req_core_id (req_core_id),
    .req_ready   (req_ready),
    .launch_valid(launch_valid),
    .launch_id   (launch_id),
    .launch_ready(launch_ready),
    .done_valid  (done_valid),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // One row: outputs expected in this cycle, then the inputs applied for it.
  typedef struct {
    string       tag;
    logic        rv;
    logic [7:0]  id;
    logic [1:0]  sz;
    logic [1:0]  core;
    logic [3:0]  lr;
    logic [3:0]  dv;
    logic        e_ready;
    logic [3:0]  e_lv;
    logic [7:0]  e_lid;
    logic        e_rsp;
    logic [7:0]  e_rid;
    logic        e_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string tag, logic rv, logic [7:0] id, logic [1:0] sz,
                              logic [1:0] core, logic [3:0] lr, logic [3:0] dv,
                              logic e_ready, logic [3:0] e_lv, logic [7:0] e_lid,
                              logic e_rsp, logic [7:0] e_rid, logic e_busy);
    vec_t v;
    v.tag = tag; v.rv = rv; v.id = id; v.sz = sz; v.core = core; v.lr = lr; v.dv = dv;
    v.e_ready = e_ready; v.e_lv = e_lv; v.e_lid = e_lid;
    v.e_rsp = e_rsp; v.e_rid = e_rid; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs(string name, logic e_ready, logic [3:0] e_lv, logic [7:0] e_lid,
                               logic e_rsp, logic [7:0] e_rid, logic e_busy);
    check({name, ".req_ready"},    32'(req_ready),    32'(e_ready));
    check({name, ".launch_valid"}, 32'(launch_valid), 32'(e_lv));
    check({name, ".rsp_valid"},    32'(rsp_valid),    32'(e_rsp));
    check({name, ".busy"},         32'(busy),         32'(e_busy));
    if (e_lv != 4'b0000) check({name, ".launch_id"}, 32'(launch_id), 32'(e_lid));
    if (e_rsp)           check({name, ".rsp_id"},    32'(rsp_id),    32'(e_rid));
  endtask

  task automatic drive(logic rv, logic [7:0] id, logic [1:0] sz, logic [1:0] core,
                       logic [3:0] lr, logic [3:0] dv);
    req_valid    = rv;
    req_id       = id;
    req_size_m1  = sz;
    req_core_id  = core;
    launch_ready = lr;
    done_valid   = dv;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Single core, immediate ready, done one cycle after the launch handshake.
    vecs.push_back(mk("basic", 1, 8'h21, 2'd0, 2'd2, 4'hF, 4'h0,  1, 4'b0000, 8'h00, 0, 8'h00, 0));
    vecs.push_back(mk("basic", 0, 8'h00, 2'd0, 2'd0, 4'hF, 4'h0,  0, 4'b0100, 8'h21, 0, 8'h00, 1));
    vecs.push_back(mk("basic", 0, 8'h00, 2'd0, 2'd0, 4'hF, 4'b0100, 0, 4'b0000, 8'h00, 0, 8'h00, 1));
    vecs.push_back(mk("basic", 0, 8'h00, 2'd0, 2'd0, 4'hF, 4'h0,  0, 4'b0000, 8'h00, 1, 8'h21, 1));
    // Four cores starting at 2: launch 2,3,0,1 then dones 1,0,3,2.
    vecs.push_back(mk("wrap",  1, 8'h5A, 2'd3, 2'd2, 4'hF, 4'h0,  1, 4'b0000, 8'h00, 0, 8'h00, 0));
    vecs.push_back(mk("wrap",  0, 8'h00, 2'd0, 2'd0, 4'hF, 4'h0,  0, 4'b0100, 8'h5A, 0, 8'h00, 1));
    vecs.push_back(mk("wrap",  0, 8'h00, 2'd0, 2'd0, 4'hF, 4'h0,  0, 4'b1000, 8'h5A, 0, 8'h00, 1));
    vecs.push_back(mk("wrap",  0, 8'h00, 2'd0, 2'd0, 4'hF, 4'h0,  0, 4'b0001, 8'h5A, 0, 8'h00, 1));
    vecs.push_back(mk("wrap",  0, 8'h00, 2'd0, 2'd0, 4'hF, 4'h0,  0, 4'b0010, 8'h5A, 0, 8'h00, 1));
    vecs.push_back(mk("wrap",  0, 8'h00, 2'd0, 2'd0, 4'hF, 4'b0010, 0, 4'b0000, 8'h00, 0, 8'h00, 1));
    vecs.push_back(mk("wrap",  0, 8'h00, 2'd0, 2'd0, 4'hF, 4'b0001, 0, 4'b0000, 8'h00, 0, 8'h00, 1));
    vecs.push_back(mk("wrap",  0, 8'h00, 2'd0, 2'd0, 4'hF, 4'b1000, 0, 4'b0000, 8'h00, 0, 8'h00, 1));
    vecs.push_back(mk("wrap",  0, 8'h00, 2'd0, 2'd0, 4'hF, 4'b0100, 0, 4'b0000, 8'h00, 0, 8'h00, 1));
    vecs.push_back(mk("wrap",  0, 8'h00, 2'd0, 2'd0, 4'hF, 4'h0,  0, 4'b0000, 8'h00, 1, 8'h5A, 1));
    vecs.push_back(mk("wrap",  0, 8'h00, 2'd0, 2'd0, 4'hF, 4'h0,  1, 4'b0000, 8'h00, 0, 8'h00, 0));

    // Reset state.
    drive(0, 8'h00, 2'd0, 2'd0, 4'h0, 4'h0);
    #3;
    check_outputs("reset", 0, 4'b0000, 8'h00, 0, 8'h00, 0);
    check("reset.launch_id", 32'(launch_id), 32'h0);
    check("reset.rsp_id",    32'(rsp_id),    32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      check_outputs($sformatf("%s[%0d]", v.tag, i), v.e_ready, v.e_lv, v.e_lid, v.e_rsp, v.e_rid, v.e_busy);
      drive(v.rv, v.id, v.sz, v.core, v.lr, v.dv);
      step();
    end

    // Back-pressure: core 1 not ready for five cycles.
    check_outputs("bp.idle", 1, 4'b0000, 8'h00, 0, 8'h00, 0);
    drive(1, 8'h33, 2'd3, 2'd0, 4'hF, 4'h0);
    step();
    check_outputs("bp.l0", 0, 4'b0001, 8'h33, 0, 8'h00, 1);
    drive(0, 8'h00, 2'd0, 2'd0, 4'b1101, 4'h0);
    step();
    for (int i = 0; i < 5; i++) begin
      check_outputs($sformatf("bp.hold%0d", i), 0, 4'b0010, 8'h33, 0, 8'h00, 1);
      drive(0, 8'h00, 2'd0, 2'd0, 4'b1101, 4'h0);
      step();
    end
    check_outputs("bp.l1", 0, 4'b0010, 8'h33, 0, 8'h00, 1);
    drive(0, 8'h00, 2'd0, 2'd0, 4'hF, 4'h0);
    step();
    check_outputs("bp.l2", 0, 4'b0100, 8'h33, 0, 8'h00, 1);
    step();
    check_outputs("bp.l3", 0, 4'b1000, 8'h33, 0, 8'h00, 1);
    step();
    check_outputs("bp.wait", 0, 4'b0000, 8'h00, 0, 8'h00, 1);
    drive(0, 8'h00, 2'd0, 2'd0, 4'hF, 4'hF);
    step();
    check_outputs("bp.rsp", 0, 4'b0000, 8'h00, 1, 8'h33, 1);
    drive(0, 8'h00, 2'd0, 2'd0, 4'hF, 4'h0);
    step();

    // Spurious done on an idle core, and done colliding with the launch handshake.
    check_outputs("sp.idle", 1, 4'b0000, 8'h00, 0, 8'h00, 0);
    drive(1, 8'h44, 2'd1, 2'd1, 4'hF, 4'h0);
    step();
    check_outputs("sp.l0", 0, 4'b0010, 8'h44, 0, 8'h00, 1);
    drive(0, 8'h00, 2'd0, 2'd0, 4'hF, 4'b1000);
    step();
    check_outputs("sp.l1", 0, 4'b0100, 8'h44, 0, 8'h00, 1);
    drive(0, 8'h00, 2'd0, 2'd0, 4'hF, 4'b0100);
    step();
    check_outputs("sp.w0", 0, 4'b0000, 8'h00, 0, 8'h00, 1);
    drive(0, 8'h00, 2'd0, 2'd0, 4'hF, 4'b0010);
    step();
    check_outputs("sp.w1", 0, 4'b0000, 8'h00, 0, 8'h00, 1);
    drive(0, 8'h00, 2'd0, 2'd0, 4'hF, 4'h0);
    step();
    check_outputs("sp.w2", 0, 4'b0000, 8'h00, 0, 8'h00, 1);
    drive(0, 8'h00, 2'd0, 2'd0, 4'hF, 4'b1000);
    step();
    check_outputs("sp.w3", 0, 4'b0000, 8'h00, 0, 8'h00, 1);
    drive(0, 8'h00, 2'd0, 2'd0, 4'hF, 4'b0100);
    step();
    check_outputs("sp.rsp", 0, 4'b0000, 8'h00, 1, 8'h44, 1);
    drive(0, 8'h00, 2'd0, 2'd0, 4'hF, 4'h0);
    step();

    // Second request held valid while the first block is in flight.
    check_outputs("st.idle", 1, 4'b0000, 8'h00, 0, 8'h00, 0);
    drive(1, 8'h55, 2'd0, 2'd3, 4'hF, 4'h0);
    step();
    check_outputs("st.l0", 0, 4'b1000, 8'h55, 0, 8'h00, 1);
    drive(1, 8'h66, 2'd0, 2'd1, 4'hF, 4'h0);
    step();
    check_outputs("st.wait", 0, 4'b0000, 8'h00, 0, 8'h00, 1);
    drive(1, 8'h66, 2'd0, 2'd1, 4'hF, 4'b1000);
    step();
    check_outputs("st.rsp", 0, 4'b0000, 8'h00, 1, 8'h55, 1);
    drive(1, 8'h66, 2'd0, 2'd1, 4'hF, 4'h0);
    step();
    check("st.accept.req_ready", 32'(req_ready), 32'h1);
    check("st.accept.rsp_valid", 32'(rsp_valid), 32'h0);
    step();
    check_outputs("st.l1", 0, 4'b0010, 8'h66, 0, 8'h00, 1);
    drive(0, 8'h00, 2'd0, 2'd0, 4'hF, 4'h0);
    step();
    check_outputs("st.wait2", 0, 4'b0000, 8'h00, 0, 8'h00, 1);
    drive(0, 8'h00, 2'd0, 2'd0, 4'hF, 4'b0010);
    step();
    check_outputs("st.rsp2", 0, 4'b0000, 8'h00, 1, 8'h66, 1);
    drive(0, 8'h00, 2'd0, 2'd0, 4'hF, 4'h0);
    step();

    // Reset while waiting on two pending cores.
    check_outputs("rs.idle", 1, 4'b0000, 8'h00, 0, 8'h00, 0);
    drive(1, 8'h77, 2'd1, 2'd0, 4'hF, 4'h0);
    step();
    check_outputs("rs.l0", 0, 4'b0001, 8'h77, 0, 8'h00, 1);
    drive(0, 8'h00, 2'd0, 2'd0, 4'hF, 4'h0);
    step();
    check_outputs("rs.l1", 0, 4'b0010, 8'h77, 0, 8'h00, 1);
    step();
    check_outputs("rs.wait", 0, 4'b0000, 8'h00, 0, 8'h00, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_outputs("rs.async", 0, 4'b0000, 8'h00, 0, 8'h00, 0);
    check("rs.async.launch_id", 32'(launch_id), 32'h0);
    check("rs.async.rsp_id",    32'(rsp_id),    32'h0);
    drive(0, 8'h00, 2'd0, 2'd0, 4'hF, 4'b0011);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    check_outputs("rs.post0", 1, 4'b0000, 8'h00, 0, 8'h00, 0);
    drive(0, 8'h00, 2'd0, 2'd0, 4'hF, 4'b0011);
    step();
    check_outputs("rs.post1", 1, 4'b0000, 8'h00, 0, 8'h00, 0);
    drive(0, 8'h00, 2'd0, 2'd0, 4'hF, 4'h0);
    step();
    check_outputs("rs.post2", 1, 4'b0000, 8'h00, 0, 8'h00, 0);
    drive(1, 8'h88, 2'd0, 2'd3, 4'hF, 4'h0);
    step();
    check_outputs("rs.l2", 0, 4'b1000, 8'h88, 0, 8'h00, 1);
    drive(0, 8'h00, 2'd0, 2'd0, 4'hF, 4'h0);
    step();
    check_outputs("rs.wait2", 0, 4'b0000, 8'h00, 0, 8'h00, 1);
    drive(0, 8'h00, 2'd0, 2'd0, 4'hF, 4'b1000);
    step();
    check_outputs("rs.rsp", 0, 4'b0000, 8'h00, 1, 8'h88, 1);
    drive(0, 8'h00, 2'd0, 2'd0, 4'hF, 4'h0);
    step();
    check_outputs("rs.done", 1, 4'b0000, 8'h00, 0, 8'h00, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
